// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC host interface.
//   - register address map
//   - STATUS bit indices
//   - one-hot function select bit positions
//   - host FSM state encoding
package cordic_pkg;

  // Register addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_ANGLE   = 3'd1;
  localparam logic [2:0] ADDR_ANOTHER = 3'd2;
  localparam logic [2:0] ADDR_RESULT  = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;
  localparam logic [2:0] ADDR_CLEAR   = 3'd5;

  // STATUS bit indices (bit0 is live, bits 1..4 are sticky)
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_RANGE   = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_OVERRUN = 4;

  // Function select bit positions
  localparam int SEL_SIN  = 0;
  localparam int SEL_COS  = 1;
  localparam int SEL_TAN  = 2;
  localparam int SEL_ATAN = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_host_if.sv
// Register-bus front end for the CORDIC coprocessor.
// Software loads ANGLE/ANOTHER, then writes CTRL with start=1 and a one-hot
// select. A valid request produces a one-cycle cordic_valid pulse, after which
// the block waits for cordic_out_valid (or times out) and records the result.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus_wr/bus_rd       register write/read strobes
//   bus_addr/bus_wdata  register address and write data
//   bus_rdata           registered read data (holds until the next read)
//   irq                 level interrupt: done | range_err | timeout | overrun
//   cordic_in_angle     angle operand (driven straight from ANGLE)
//   cordic_another      second operand (driven straight from ANOTHER)
//   cordic_select       latched one-hot function select
//   cordic_valid        single-cycle request strobe
//   cordic_out          coprocessor result, Q7.8
//   cordic_out_valid    result strobe
module cordic_host_if
  import cordic_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32,
  parameter int MAX_ANGLE      = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [2:0]  bus_addr,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        irq,
  output logic [15:0] cordic_in_angle,
  output logic [15:0] cordic_another,
  output logic [3:0]  cordic_select,
  output logic        cordic_valid,
  input  logic [15:0] cordic_out,
  input  logic        cordic_out_valid
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic signed [15:0] MAX_ANGLE_S = 16'(MAX_ANGLE);

  state_t             state_reg, state_next;
  logic [15:0]        angle_reg;
  logic [15:0]        another_reg;
  logic [3:0]         sel_reg;
  logic [15:0]        result_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [15:0]        rdata_reg;
  // Sticky STATUS bits, indexed by their STATUS bit position
  logic [ST_OVERRUN:ST_DONE] sticky_reg;
  logic [ST_OVERRUN:ST_DONE] sticky_set;
  logic [ST_OVERRUN:ST_DONE] sticky_clr;

  logic        busy;
  logic        wr_ctrl, wr_angle, wr_another, wr_clear, rd_result;
  logic [3:0]  wr_sel;
  logic        sel_onehot, needs_angle, angle_in_range;
  logic        start_req, start_ok, start_bad;
  logic        capture, timed_out, overrun_hit;
  logic [4:0]  status_word;
  logic [15:0] rd_mux;

  assign busy       = (state_reg != S_IDLE);
  assign wr_ctrl    = bus_wr && (bus_addr == ADDR_CTRL);
  assign wr_angle   = bus_wr && (bus_addr == ADDR_ANGLE);
  assign wr_another = bus_wr && (bus_addr == ADDR_ANOTHER);
  assign wr_clear   = bus_wr && (bus_addr == ADDR_CLEAR);
  assign rd_result  = bus_rd && (bus_addr == ADDR_RESULT);

  // Request validation uses the select being written and the current ANGLE.
  assign wr_sel         = bus_wdata[7:4];
  assign sel_onehot     = $onehot(wr_sel);
  assign needs_angle    = wr_sel[SEL_SIN] | wr_sel[SEL_COS] | wr_sel[SEL_TAN];
  assign angle_in_range = ($signed(angle_reg) >= 16'sd0) &&
                          ($signed(angle_reg) <= MAX_ANGLE_S);

  // Start is only honoured in IDLE; while busy it counts as an overrun.
  assign start_req = wr_ctrl && bus_wdata[0] && !busy;
  assign start_ok  = start_req && sel_onehot && (!needs_angle || angle_in_range);
  assign start_bad = start_req && !start_ok;

  assign capture     = (state_reg == S_WAIT) && cordic_out_valid;
  assign timed_out   = (state_reg == S_WAIT) && !cordic_out_valid && (cnt_reg == CNT_LAST);
  assign overrun_hit = busy && (wr_ctrl || wr_angle || wr_another);

  // Sets and clears for the sticky bits; a set in the same cycle as a clear
  // wins because the update is set | (old & ~clr).
  always_comb begin
    sticky_set = '0;
    sticky_clr = '0;
    sticky_set[ST_DONE]    = capture;
    sticky_set[ST_RANGE]   = start_bad;
    sticky_set[ST_TIMEOUT] = timed_out;
    sticky_set[ST_OVERRUN] = overrun_hit;
    if (wr_clear) begin
      sticky_clr = bus_wdata[ST_OVERRUN:ST_DONE];
    end
    if (start_req || rd_result) begin
      sticky_clr[ST_DONE] = 1'b1;
    end
  end

  // FSM: next state and request strobe
  always_comb begin
    state_next   = state_reg;
    cordic_valid = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (start_ok) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        cordic_valid = 1'b1;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (capture || timed_out) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  assign status_word = {sticky_reg, busy};

  // Read mux sees pre-write values, so a read racing a write returns old data.
  always_comb begin
    rd_mux = '0;
    unique case (bus_addr)
      ADDR_CTRL:    rd_mux = {8'd0, sel_reg, 4'd0};
      ADDR_ANGLE:   rd_mux = angle_reg;
      ADDR_ANOTHER: rd_mux = another_reg;
      ADDR_RESULT:  rd_mux = result_reg;
      ADDR_STATUS:  rd_mux = {11'd0, status_word};
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      angle_reg   <= '0;
      another_reg <= '0;
      sel_reg     <= '0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      rdata_reg   <= '0;
      sticky_reg  <= '0;
    end else begin
      if (wr_angle && !busy)   angle_reg   <= bus_wdata;
      if (wr_another && !busy) another_reg <= bus_wdata;
      if (start_ok)            sel_reg     <= wr_sel;
      if (capture)             result_reg  <= cordic_out;

      if (state_reg == S_ISSUE)     cnt_reg <= '0;
      else if (state_reg == S_WAIT) cnt_reg <= cnt_reg + 1'b1;

      if (bus_rd) rdata_reg <= rd_mux;

      sticky_reg <= sticky_set | (sticky_reg & ~sticky_clr);
    end
  end

  assign bus_rdata       = rdata_reg;
  assign irq             = |sticky_reg;
  assign cordic_in_angle = angle_reg;
  assign cordic_another  = another_reg;
  assign cordic_select   = sel_reg;

endmodule
